// File: rtl/onn_settle_ctrl.sv
// onn_settle_ctrl
//   Sequences one settle run of the ONN phase-register array. A run loads the
//   initial phases, then strobes a state check on every accepted oscillation
//   period and watches the per-neuron change flags. The run ends when no neuron
//   has changed for STABLE_PERIODS consecutive checks (converged) or when
//   MAX_PERIODS checks have been made (timeout).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start; counters and result flags cleared
//   S_LOAD    | one-cycle load pulse (ren & drop) into the phase registers
//   S_WAIT    | waiting for the next full_tick
//   S_CHECK   | one-cycle state_cheak strobe; period counter advances
//   S_EVAL    | samples state_changed and decides converge / timeout / next
//   S_DONE    | result held; start must be seen low before a relaunch
//
// Ports
//   sclk_i           system clock, rising edge
//   re_i             asynchronous active-high reset
//   start_i          level, launches a run from IDLE or (re-armed) DONE
//   abort_i          returns to IDLE on the next edge from any state
//   full_tick_i      one-cycle pulse per oscillation period
//   state_changed_i  per-neuron change flags from the phase registers
//   ren_o, drop_o    load enable / load strobe (both high = load)
//   state_cheak_o    one-cycle state-check strobe
//   busy_o           high in LOAD, WAIT, CHECK, EVAL
//   done_o           high in DONE
//   converged_o      run ended by convergence (valid while done)
//   timeout_o        run ended by period limit (valid while done)
//   period_cnt_o     checks completed in the current / last run

module onn_settle_ctrl #(
  parameter int N_NEURONS      = 15,
  parameter int STABLE_PERIODS = 3,
  parameter int MAX_PERIODS    = 64,
  parameter int PCNT_W         = 7
) (
  input  logic                 sclk_i,
  input  logic                 re_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 full_tick_i,
  input  logic [N_NEURONS-1:0] state_changed_i,
  output logic                 ren_o,
  output logic                 drop_o,
  output logic                 state_cheak_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 converged_o,
  output logic                 timeout_o,
  output logic [PCNT_W-1:0]    period_cnt_o
);

  localparam int SCNT_W = $clog2(STABLE_PERIODS + 1);
  localparam logic [SCNT_W-1:0] STABLE_CNT = SCNT_W'(STABLE_PERIODS);
  localparam logic [PCNT_W-1:0] MAX_CNT    = PCNT_W'(MAX_PERIODS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_EVAL,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [PCNT_W-1:0]   period_cnt_q;
  logic [SCNT_W-1:0]   stable_cnt_q;
  logic [SCNT_W-1:0]   stable_cnt_d;
  logic                armed_q;
  logic                ren_q;
  logic                drop_q;
  logic                chk_q;
  logic                busy_q;
  logic                done_q;
  logic                conv_q;
  logic                tmo_q;
  logic                any_chg;

  assign any_chg = |state_changed_i;

  // Quiet-check run length after this EVAL; saturates so it can never wrap.
  assign stable_cnt_d = any_chg                      ? '0 :
                        (stable_cnt_q == STABLE_CNT) ? stable_cnt_q :
                                                       stable_cnt_q + SCNT_W'(1);

  always_ff @(posedge sclk_i or posedge re_i) begin
    if (re_i) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      stable_cnt_q <= '0;
      armed_q      <= 1'b0;
      ren_q        <= 1'b0;
      drop_q       <= 1'b0;
      chk_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      conv_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below raises them again.
      ren_q  <= 1'b0;
      drop_q <= 1'b0;
      chk_q  <= 1'b0;

      if (abort_i) begin
        state_q      <= S_IDLE;
        period_cnt_q <= '0;
        stable_cnt_q <= '0;
        armed_q      <= 1'b0;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        conv_q       <= 1'b0;
        tmo_q        <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            period_cnt_q <= '0;
            stable_cnt_q <= '0;
            conv_q       <= 1'b0;
            tmo_q        <= 1'b0;
            if (start_i) begin
              state_q <= S_LOAD;
              ren_q   <= 1'b1;
              drop_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end

          // A tick coincident with the load cycle is deliberately dropped.
          S_LOAD: state_q <= S_WAIT;

          S_WAIT: begin
            if (full_tick_i) begin
              state_q <= S_CHECK;
              chk_q   <= 1'b1;
            end
          end

          S_CHECK: begin
            period_cnt_q <= period_cnt_q + PCNT_W'(1);
            state_q      <= S_EVAL;
          end

          // Convergence is tested first so it wins a tie with the period limit.
          S_EVAL: begin
            stable_cnt_q <= stable_cnt_d;
            if (stable_cnt_d == STABLE_CNT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              conv_q  <= 1'b1;
              armed_q <= 1'b0;
            end else if (period_cnt_q == MAX_CNT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tmo_q   <= 1'b1;
              armed_q <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end

          // A start held high across the end of a run must drop once before
          // it can relaunch, so a stuck start cannot free-run the array.
          S_DONE: begin
            if (!start_i) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q      <= S_LOAD;
              ren_q        <= 1'b1;
              drop_q       <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              period_cnt_q <= '0;
              stable_cnt_q <= '0;
              conv_q       <= 1'b0;
              tmo_q        <= 1'b0;
              armed_q      <= 1'b0;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ren_o         = ren_q;
  assign drop_o        = drop_q;
  assign state_cheak_o = chk_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign converged_o   = conv_q;
  assign timeout_o     = tmo_q;
  assign period_cnt_o  = period_cnt_q;

endmodule

// File: tb/tb_onn_settle_ctrl.sv
module tb_onn_settle_ctrl;

  localparam int N = 15;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Default-parameter instance
  logic         re, start, abort, full_tick;
  logic [N-1:0] sc = '0;
  logic         ren, drop, chk, busy, done, conv, tmo;
  logic [6:0]   pcnt;

  // Short-limit instance (MAX_PERIODS = 5) for the convergence/timeout tie
  logic         re5, start5, abort5, tick5;
  logic [N-1:0] sc5 = '0;
  logic         ren5, drop5, chk5, busy5, done5, conv5, tmo5;
  logic [2:0]   pcnt5;

  onn_settle_ctrl dut (
    .sclk_i(sclk), .re_i(re), .start_i(start), .abort_i(abort),
    .full_tick_i(full_tick), .state_changed_i(sc),
    .ren_o(ren), .drop_o(drop), .state_cheak_o(chk), .busy_o(busy),
    .done_o(done), .converged_o(conv), .timeout_o(tmo), .period_cnt_o(pcnt)
  );

  onn_settle_ctrl #(.N_NEURONS(15), .STABLE_PERIODS(3), .MAX_PERIODS(5), .PCNT_W(3)) dut5 (
    .sclk_i(sclk), .re_i(re5), .start_i(start5), .abort_i(abort5),
    .full_tick_i(tick5), .state_changed_i(sc5),
    .ren_o(ren5), .drop_o(drop5), .state_cheak_o(chk5), .busy_o(busy5),
    .done_o(done5), .converged_o(conv5), .timeout_o(tmo5), .period_cnt_o(pcnt5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic conv;
    logic tmo;
    int   pcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp5_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Change-flag pattern for check number n (1-based) of a run
  function automatic logic [N-1:0] pat(input int m, input int n);
    logic [N-1:0] r;
    r = '0;
    case (m)
      1: r = (n <= 4) ? 15'h0010 : 15'h0000;
      2: r = n[0] ? 15'h0001 : 15'h0002;
      3: r = (n <= 2) ? 15'h0100 : 15'h0000;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Phase-register model: presents change flags for the EVAL after each strobe
  int mode = 0, mode5 = 0;
  int nchk = 0, nchk5 = 0;

  always @(negedge sclk) begin
    if (ren && drop) nchk = 0;
    if (chk) begin
      nchk = nchk + 1;
      sc = pat(mode, nchk);
    end
  end

  always @(negedge sclk) begin
    if (ren5 && drop5) nchk5 = 0;
    if (chk5) begin
      nchk5 = nchk5 + 1;
      sc5 = pat(mode5, nchk5);
    end
  end

  // Scoreboard monitors: compare the run result whenever done rises
  logic done_d = 1'b0, done5_d = 1'b0;
  exp_t e, e5;

  always @(negedge sclk) begin
    if (done && !done_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("run_converged", int'(conv), int'(e.conv));
        check("run_timeout", int'(tmo), int'(e.tmo));
        check("run_period_cnt", int'(pcnt), e.pcnt);
        check("run_busy_low", int'(busy), 0);
      end
    end
    done_d = done;
  end

  always @(negedge sclk) begin
    if (done5 && !done5_d) begin
      if (exp5_q.size() == 0) begin
        check("unexpected_done5", 1, 0);
      end else begin
        e5 = exp5_q.pop_front();
        check("tie_converged", int'(conv5), int'(e5.conv));
        check("tie_timeout", int'(tmo5), int'(e5.tmo));
        check("tie_period_cnt", int'(pcnt5), e5.pcnt);
      end
    end
    done5_d = done5;
  end

  function automatic exp_t mk(input logic c, input logic t, input int p);
    exp_t x;
    x.conv = c;
    x.tmo  = t;
    x.pcnt = p;
    return x;
  endfunction

  // Pulse full_tick every 4th cycle until done rises or the budget expires
  task automatic run_ticks(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      full_tick = (i % 4 == 0);
      @(negedge sclk);
    end
    full_tick = 1'b0;
    check("run_reaches_done", int'(done), 1);
  endtask

  task automatic pulse_start();
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  int loads;
  int nck;

  initial begin
    re = 1'b1; start = 1'b0; abort = 1'b0; full_tick = 1'b0;
    re5 = 1'b1; start5 = 1'b0; abort5 = 1'b0; tick5 = 1'b0;
    repeat (3) @(negedge sclk);

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'({ren, drop, chk}), 0);
    check("rst_flags", int'({conv, tmo}), 0);
    check("rst_period_cnt", int'(pcnt), 0);
    re = 1'b0;
    re5 = 1'b0;
    @(negedge sclk);

    // Quick convergence with latency checks on the first period
    mode = 0;
    exp_q.push_back(mk(1'b1, 1'b0, 3));
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    check("start_to_load", int'(ren & drop), 1);
    check("load_busy", int'(busy), 1);
    @(negedge sclk);
    check("load_one_cycle", int'(ren | drop), 0);
    full_tick = 1'b1;
    @(negedge sclk);
    full_tick = 1'b0;
    check("tick_to_check", int'(chk), 1);
    @(negedge sclk);
    check("check_one_cycle", int'(chk), 0);
    run_ticks(100);

    // Changes on checks 1-4, then quiet: converges at 7
    mode = 1;
    exp_q.push_back(mk(1'b1, 1'b0, 7));
    pulse_start();
    run_ticks(200);

    // A neuron toggles every check: timeout at 64
    mode = 2;
    exp_q.push_back(mk(1'b0, 1'b1, 64));
    pulse_start();
    run_ticks(400);

    // Start held high through DONE must not relaunch
    mode = 0;
    exp_q.push_back(mk(1'b1, 1'b0, 3));
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    run_ticks(100);
    loads = 0;
    repeat (10) begin
      @(negedge sclk);
      if (ren && drop) loads++;
    end
    check("held_start_no_relaunch", loads, 0);
    check("held_start_done", int'(done), 1);
    check("held_start_pcnt_hold", int'(pcnt), 3);

    // Drop start for one cycle, raise it: load one cycle later
    exp_q.push_back(mk(1'b1, 1'b0, 3));
    start = 1'b0;
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    check("rearm_load", int'(ren & drop), 1);
    check("rearm_done_cleared", int'(done), 0);
    run_ticks(100);
    start = 1'b0;

    // Abort while waiting for a tick, after one completed check
    mode = 2;
    pulse_start();
    @(negedge sclk);
    full_tick = 1'b1;
    @(negedge sclk);
    full_tick = 1'b0;
    repeat (3) @(negedge sclk);
    check("abort_pre_pcnt", int'(pcnt), 1);
    check("abort_pre_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pcnt", int'(pcnt), 0);

    // Tick held high from the load cycle on: load-cycle tick ignored,
    // then only every third cycle is accepted
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    full_tick = 1'b1;
    @(negedge sclk);
    check("tick_in_load_ignored", int'(chk), 0);
    nck = 0;
    repeat (9) begin
      @(negedge sclk);
      if (chk) nck++;
    end
    check("b2b_ticks_accepted", nck, 3);
    full_tick = 1'b0;
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;

    // Reset asserted during the second CHECK cycle
    mode = 2;
    pulse_start();
    @(negedge sclk);
    full_tick = 1'b1;
    @(negedge sclk);
    full_tick = 1'b0;
    repeat (2) @(negedge sclk);
    full_tick = 1'b1;
    @(negedge sclk);
    full_tick = 1'b0;
    check("pre_reset_in_check", int'(chk), 1);
    check("pre_reset_pcnt", int'(pcnt), 1);
    re = 1'b1;
    #1;
    check("reset_chk", int'(chk), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pcnt", int'(pcnt), 0);
    @(negedge sclk);
    re = 1'b0;
    @(negedge sclk);

    // Convergence and period limit in the same EVAL (MAX_PERIODS = 5)
    mode5 = 3;
    exp5_q.push_back(mk(1'b1, 1'b0, 5));
    start5 = 1'b1;
    @(negedge sclk);
    start5 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done5) break;
      tick5 = (i % 4 == 0);
      @(negedge sclk);
    end
    tick5 = 1'b0;
    check("tie_reaches_done", int'(done5), 1);

    repeat (2) @(negedge sclk);
    check("scoreboard_drained", exp_q.size() + exp5_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
